knn_distance_calc: RTL and testbench
====================================

// Module: knn_distance_calc
// PURPOSE
//  Streaming squared-Euclidean distance engine; the stage directly upstream of the k-sorter.
//  Holds one query vector of DIMENSIONS elements and consumes training samples one element per beat.
//  Emits one saturated distance per sample on a valid/ready port; m_valid/m_distance feed the sorter's valid/dataValueIn.
// PARAMETERS
//  DATA_WIDTH  32  width of one unsigned vector element (query and sample)
//  DIMENSIONS  32  elements per vector; must be >= 2
//  VAL_WIDTH   32  width of emitted distance (saturating)
// PORTS
//  clk             in   1           rising-edge clock
//  resetn          in   1           synchronous, active-low reset
//  q_valid         in   1           query element present
//  q_ready         out  1           query element accepted (high only in LOAD)
//  q_data          in   DATA_WIDTH  query element, index auto-increments 0..DIMENSIONS-1
//  reload          in   1           request new query load (pulse)
//  s_valid         in   1           sample element present
//  s_ready         out  1           sample element accepted (high only in ACCUM)
//  s_data          in   DATA_WIDTH  sample element, index auto-increments 0..DIMENSIONS-1
//  s_last          in   1           qualifies final beat of the final sample vector of a dataset
//  m_valid         out  1           distance available
//  m_ready         in   1           downstream accepts distance
//  m_distance      out  VAL_WIDTH   squared distance of the most recent sample
//  m_last          out  1           distance belongs to the vector whose last beat had s_last=1
// BEHAVIOUR
//  - Reset (resetn=0 at a clk edge): state=LOAD; q_idx=s_idx=0; acc=0; pipe valids=0;
//    m_valid=0, m_distance=0, m_last=0; q_ready=1, s_ready=0 from the first cycle after.
//    Query RAM is not cleared. Reset mid-vector or mid-output discards all in-flight work.
//  - FSM states: LOAD, ACCUM, DRAIN, OUT.
//    LOAD: q_ready=1; each q_valid beat writes qmem[q_idx], q_idx++. Beat with q_idx=DIMENSIONS-1
//      -> q_idx=0, next state ACCUM.
//    ACCUM: s_ready=1; each s_valid beat pushes (s_data, qmem[s_idx]) into pipeline, s_idx++.
//      Beat with s_idx=DIMENSIONS-1 -> s_idx=0, latch s_last into last_flag, next state DRAIN.
//      reload=1 while s_idx=0 and no s_valid beat that cycle -> LOAD; otherwise reload is ignored
//      (not queued). If s_valid and reload coincide at s_idx=0, the sample beat wins.
//    DRAIN: s_ready=0; wait until the final element's product has entered acc, then -> OUT.
//    OUT: m_valid=1, m_distance and m_last stable until m_ready=1; on handshake
//      acc cleared, m_valid=0 next cycle, next state ACCUM.
//  - Pipeline per element: stage1 |s-q| (DATA_WIDTH, registered); stage2 square
//    (2*DATA_WIDTH, registered); stage3 acc += square, ACC_WIDTH = 2*DATA_WIDTH+clog2(DIMENSIONS).
//    Stages advance only when their valid bit is set; bubbles (s_valid=0) carry no data.
//  - Latency: final beat accepted at edge T -> m_valid=1 after edge T+3.
//    Throughput: one element/cycle inside a vector; 4+ dead cycles per vector.
//  - Saturation: m_distance = (acc[ACC_WIDTH-1:VAL_WIDTH] != 0) ? all-ones : acc[VAL_WIDTH-1:0].
//  - Backpressure: m_ready low holds OUT indefinitely; s_ready stays 0; no sample beats lost.
//  - q_data/s_data are ignored when their ready is low; no X propagates to m_distance.
// STRUCTURE
//  - knn_pkg: FSM state localparams, clog2 function, ACC_WIDTH derivation; shared with the k-sorter bench.
//  - Sub-module knn_sq_diff: two-stage registered |a-b| then square, with valid pipe bit.
//  - Top: qmem (DIMENSIONS x DATA_WIDTH regs), counters, FSM, accumulator, output register.
// TESTING (bench uses DIMENSIONS=4, DATA_WIDTH=8, VAL_WIDTH=16 unless stated)
//  1. Load q=[1,2,3,4], send s=[1,2,3,4], m_ready=1 -> m_distance=0, m_valid exactly at T+3, one cycle.
//  2. Same q, s=[4,4,4,4] then s=[0,0,0,0] (s_last on final beat) -> 14 (m_last=0) then 30 (m_last=1).
//  3. Hold m_ready=0 for 5 cycles in OUT -> m_valid/m_distance stable, s_ready=0, next vector intact.
//  4. VAL_WIDTH=16, q=[0,0,0,0], s=[255,255,255,255] -> acc=260100, m_distance=16'hFFFF.
//  5. Deassert resetn after 2 sample beats -> next cycle q_ready=1, s_ready=0, m_valid=0; after
//     reloading q=[1,2,3,4], s=[1,2,3,5] -> m_distance=1.
//  6. reload at s_idx=2 ignored (result of full vector still emitted); reload at s_idx=0 -> q_ready=1.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared definitions for the kNN distance engine and k-sorter bench.
// Holds the FSM state encodings and the accumulator width helpers.
package knn_pkg;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int accWidth(input int dataWidth, input int dims);
      return 2 * dataWidth + clog2(dims);
   endfunction

endpackage

// File: rtl/knn_sq_diff.sv
// Two-stage element pipe: registered |a-b|, then registered square.
// Data registers only load when their valid bit is set, so bubbles carry nothing.
module knn_sq_diff
   import knn_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    inValid,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    diffValid,
   output logic                    sqValid,
   output logic [2*DATA_WIDTH-1:0] square
);

   logic [DATA_WIDTH-1:0] absDiff;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         diffValid <= 1'b0;
         sqValid   <= 1'b0;
         absDiff   <= '0;
         square    <= '0;
      end else begin
         diffValid <= inValid;
         sqValid   <= diffValid;
         if (inValid) begin
            absDiff <= (a > b) ? (a - b) : (b - a);
         end
         if (diffValid) begin
            square <= {{DATA_WIDTH{1'b0}}, absDiff} * {{DATA_WIDTH{1'b0}}, absDiff};
         end
      end
   end

endmodule

// File: rtl/knn_distance_calc.sv
// Streaming squared-Euclidean distance engine feeding the k-sorter.
// Loads one query vector, then emits one saturated distance per sample vector.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_LOAD  | accepting query elements into qmem
//   ST_ACCUM | accepting sample elements into the element pipe
//   ST_DRAIN | waiting for the last element's square to reach acc
//   ST_OUT   | distance presented, held until m_ready
module knn_distance_calc
   import knn_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIMENSIONS = 32,
   parameter int VAL_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  q_valid,
   output logic                  q_ready,
   input  logic [DATA_WIDTH-1:0] q_data,
   input  logic                  reload,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [VAL_WIDTH-1:0]  m_distance,
   output logic                  m_last
);

   localparam int IDX_W = clog2(DIMENSIONS);
   localparam int ACC_W = accWidth(DATA_WIDTH, DIMENSIONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIMENSIONS - 1);

   logic [1:0]              state, nextState;
   logic [IDX_W-1:0]        qIdx, sIdx;
   logic [DATA_WIDTH-1:0]   qmem [DIMENSIONS];
   logic [ACC_W-1:0]        acc;
   logic                    lastFlag;
   logic                    qBeat, sBeat;
   logic                    diffValid, sqValid;
   logic [2*DATA_WIDTH-1:0] square;
   logic [VAL_WIDTH-1:0]    satValue;

   assign q_ready = (state == ST_LOAD);
   assign s_ready = (state == ST_ACCUM);
   assign m_valid = (state == ST_OUT);
   assign qBeat   = q_ready & q_valid;
   assign sBeat   = s_ready & s_valid;

   knn_sq_diff #(.DATA_WIDTH(DATA_WIDTH)) u_sqDiff (
      .clk       (clk),
      .resetn    (resetn),
      .inValid   (sBeat),
      .a         (s_data),
      .b         (qmem[sIdx]),
      .diffValid (diffValid),
      .sqValid   (sqValid),
      .square    (square)
   );

   generate
      if (ACC_W > VAL_WIDTH) begin : g_sat
         assign satValue = (|acc[ACC_W-1:VAL_WIDTH]) ? '1 : acc[VAL_WIDTH-1:0];
      end else begin : g_noSat
         assign satValue = VAL_WIDTH'(acc);
      end
   endgenerate

   always_comb begin
      nextState = state;
      case (state)
         ST_LOAD: begin
            if (qBeat && qIdx == LAST_IDX) nextState = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (sBeat && sIdx == LAST_IDX) begin
               nextState = ST_DRAIN;
            end else if (!s_valid && reload && sIdx == '0) begin
               nextState = ST_LOAD;
            end
         end
         // The final beat always sets diffValid, so both valids low means acc is complete.
         ST_DRAIN: begin
            if (!diffValid && !sqValid) nextState = ST_OUT;
         end
         ST_OUT: begin
            if (m_ready) nextState = ST_ACCUM;
         end
         default: nextState = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_LOAD;
         qIdx       <= '0;
         sIdx       <= '0;
         acc        <= '0;
         lastFlag   <= 1'b0;
         m_distance <= '0;
         m_last     <= 1'b0;
      end else begin
         state <= nextState;
         if (qBeat) begin
            qIdx <= (qIdx == LAST_IDX) ? '0 : qIdx + 1'b1;
         end
         if (sBeat) begin
            sIdx <= (sIdx == LAST_IDX) ? '0 : sIdx + 1'b1;
            if (sIdx == LAST_IDX) lastFlag <= s_last;
         end
         if (state == ST_OUT && m_ready) begin
            acc <= '0;
         end else if (sqValid) begin
            acc <= acc + ACC_W'(square);
         end
         if (state == ST_DRAIN && nextState == ST_OUT) begin
            m_distance <= satValue;
            m_last     <= lastFlag;
         end
      end
   end

   // Query RAM is intentionally left uncleared by reset.
   always_ff @(posedge clk) begin
      if (resetn && qBeat) begin
         qmem[qIdx] <= q_data;
      end
   end

endmodule

// File: tb/tb_knn_distance_calc.sv
// Directed bench for knn_distance_calc with DIMENSIONS=4, DATA_WIDTH=8, VAL_WIDTH=16.
module tb_knn_distance_calc;

   localparam int DW  = 8;
   localparam int DIM = 4;
   localparam int VW  = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          q_valid = 1'b0;
   logic          q_ready;
   logic [DW-1:0] q_data = '0;
   logic          reload = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [VW-1:0] m_distance;
   logic          m_last;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   knn_distance_calc #(.DATA_WIDTH(DW), .DIMENSIONS(DIM), .VAL_WIDTH(VW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .q_valid    (q_valid),
      .q_ready    (q_ready),
      .q_data     (q_data),
      .reload     (reload),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_distance (m_distance),
      .m_last     (m_last)
   );

   // Vectors are packed {e3, e2, e1, e0}.
   task automatic loadQuery(input logic [4*DW-1:0] vec);
      for (int i = 0; i < DIM; i++) begin
         @(negedge clk);
         q_valid = 1'b1;
         q_data  = vec[DW*i +: DW];
      end
      @(negedge clk);
      q_valid = 1'b0;
      q_data  = '0;
   endtask

   task automatic sendSample(input logic [4*DW-1:0] vec, input logic last);
      for (int i = 0; i < DIM; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = vec[DW*i +: DW];
         s_last  = last && (i == DIM - 1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
   endtask

   task automatic waitOut(output int lat);
      lat = 0;
      while (!m_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      tests++; if (q_ready !== 1'b1) begin errors++; $display("FAIL reset_q_ready got %b want 1", q_ready); end
      tests++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
      tests++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      tests++; if (m_distance !== 16'd0) begin errors++; $display("FAIL reset_m_distance got %0d want 0", m_distance); end
      tests++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
   endtask

   task automatic test_zero_distance();
      int lat;
      loadQuery({8'd4, 8'd3, 8'd2, 8'd1});
      tests++; if (s_ready !== 1'b1) begin errors++; $display("FAIL zero_s_ready got %b want 1", s_ready); end
      sendSample({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
      waitOut(lat);
      tests++; if (lat !== 3) begin errors++; $display("FAIL zero_latency got %0d want 3", lat); end
      tests++; if (m_distance !== 16'd0) begin errors++; $display("FAIL zero_distance got %0d want 0", m_distance); end
      @(negedge clk);
      tests++; if (m_valid !== 1'b0) begin errors++; $display("FAIL zero_one_cycle got %b want 0", m_valid); end
   endtask

   task automatic test_two_vectors();
      int lat;
      sendSample({8'd4, 8'd4, 8'd4, 8'd4}, 1'b0);
      waitOut(lat);
      tests++; if (m_valid !== 1'b1) begin errors++; $display("FAIL two_a_valid got %b want 1", m_valid); end
      tests++; if (m_distance !== 16'd14) begin errors++; $display("FAIL two_a_distance got %0d want 14", m_distance); end
      tests++; if (m_last !== 1'b0) begin errors++; $display("FAIL two_a_last got %b want 0", m_last); end
      @(negedge clk);
      sendSample({8'd0, 8'd0, 8'd0, 8'd0}, 1'b1);
      waitOut(lat);
      tests++; if (lat !== 3) begin errors++; $display("FAIL two_b_latency got %0d want 3", lat); end
      tests++; if (m_distance !== 16'd30) begin errors++; $display("FAIL two_b_distance got %0d want 30", m_distance); end
      tests++; if (m_last !== 1'b1) begin errors++; $display("FAIL two_b_last got %b want 1", m_last); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int lat;
      m_ready = 1'b0;
      sendSample({8'd2, 8'd2, 8'd2, 8'd2}, 1'b0);
      waitOut(lat);
      s_valid = 1'b1;
      s_data  = 8'hAA;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (m_valid !== 1'b1 || m_distance !== 16'd6 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d got valid=%b dist=%0d s_ready=%b want 1/6/0",
                     i, m_valid, m_distance, s_ready);
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;
      @(negedge clk);
      tests++; if (m_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", m_valid); end
      sendSample({8'd3, 8'd2, 8'd1, 8'd0}, 1'b0);
      waitOut(lat);
      tests++; if (m_distance !== 16'd4) begin errors++; $display("FAIL hold_next_distance got %0d want 4", m_distance); end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      int lat;
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      tests++; if (q_ready !== 1'b1 || s_ready !== 1'b0) begin
         errors++; $display("FAIL sat_reload got q_ready=%b s_ready=%b want 1/0", q_ready, s_ready);
      end
      loadQuery({8'd0, 8'd0, 8'd0, 8'd0});
      sendSample({8'd255, 8'd255, 8'd255, 8'd255}, 1'b0);
      waitOut(lat);
      tests++; if (m_distance !== 16'hFFFF) begin errors++; $display("FAIL sat_distance got %h want ffff", m_distance); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'd5;
      @(negedge clk);
      s_data  = 8'd6;
      @(negedge clk);
      s_valid = 1'b0;
      resetn  = 1'b0;
      @(negedge clk);
      resetn  = 1'b1;
      tests++; if (q_ready !== 1'b1) begin errors++; $display("FAIL mid_q_ready got %b want 1", q_ready); end
      tests++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready got %b want 0", s_ready); end
      tests++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid got %b want 0", m_valid); end
      loadQuery({8'd4, 8'd3, 8'd2, 8'd1});
      sendSample({8'd5, 8'd3, 8'd2, 8'd1}, 1'b0);
      waitOut(lat);
      tests++; if (m_distance !== 16'd1 || m_valid !== 1'b1) begin
         errors++; $display("FAIL mid_distance got %0d valid=%b want 1 valid=1", m_distance, m_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_reload();
      int lat;
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'd2;
      @(negedge clk);
      s_data = 8'd3;
      @(negedge clk);
      s_valid = 1'b0; reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      tests++; if (s_ready !== 1'b1 || q_ready !== 1'b0) begin
         errors++; $display("FAIL reload_mid got s_ready=%b q_ready=%b want 1/0", s_ready, q_ready);
      end
      s_valid = 1'b1; s_data = 8'd4;
      @(negedge clk);
      s_data = 8'd5;
      @(negedge clk);
      s_valid = 1'b0; s_data = '0;
      waitOut(lat);
      tests++; if (lat !== 3 || m_distance !== 16'd4) begin
         errors++; $display("FAIL reload_mid_result got lat=%0d dist=%0d want 3/4", lat, m_distance);
      end
      @(negedge clk);
      reload = 1'b1; s_valid = 1'b1; s_data = 8'd1;
      @(negedge clk);
      reload = 1'b0;
      tests++; if (q_ready !== 1'b0) begin errors++; $display("FAIL reload_coincide got q_ready=%b want 0", q_ready); end
      s_data = 8'd2;
      @(negedge clk);
      s_data = 8'd3;
      @(negedge clk);
      s_data = 8'd4;
      @(negedge clk);
      s_valid = 1'b0; s_data = '0;
      waitOut(lat);
      tests++; if (m_valid !== 1'b1 || m_distance !== 16'd0) begin
         errors++; $display("FAIL reload_coincide_result got valid=%b dist=%0d want 1/0", m_valid, m_distance);
      end
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      tests++; if (q_ready !== 1'b1 || s_ready !== 1'b0) begin
         errors++; $display("FAIL reload_idle got q_ready=%b s_ready=%b want 1/0", q_ready, s_ready);
      end
   endtask

   initial begin
      test_reset();
      test_zero_distance();
      test_two_vectors();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      test_reload();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d tests", tests);
      $fatal(1, "watchdog");
   end

endmodule
